// File: rtl/dfr_pkg.sv
// dfr_pkg: shared FSM state type and default widths for the DFR readout
package dfr_pkg;
  localparam int DFR_NODES = 100;
  localparam int DFR_DW    = 32;
  localparam int DFR_AW    = 16;
  localparam int DFR_FRAC  = 16;
  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, WRITE, DONE} dfr_state_t;
endpackage

// File: rtl/dfr_mac.sv
// dfr_mac: registered signed multiply followed by a clearable wrapping accumulator
module dfr_mac #(
  parameter int W = 32
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESETN,
  input  logic                  in_valid,
  input  logic                  clr,
  input  logic signed [W-1:0]   a,
  input  logic signed [W-1:0]   b,
  output logic signed [2*W-1:0] acc
);
  logic signed [2*W-1:0] prod;
  logic                  prod_valid, prod_clr;
  // product stage, then accumulate; the first product of a sample replaces the sum
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      prod       <= '0;
      prod_valid <= 1'b0;
      prod_clr   <= 1'b0;
      acc        <= '0;
    end else begin
      prod_valid <= in_valid;
      prod_clr   <= clr;
      if (in_valid) prod <= a * b;
      if (prod_valid) acc <= prod_clr ? prod : acc + prod;
    end
  end
endmodule

// File: rtl/dfr_readout.sv
// dfr_readout: per-sample dot product of reservoir history with readout weights
module dfr_readout
  import dfr_pkg::*;
#(
  parameter int NUM_VIRTUAL_NODES            = DFR_NODES,
  parameter int RESERVOIR_DATA_WIDTH         = DFR_DW,
  parameter int RESERVOIR_HISTORY_ADDR_WIDTH = DFR_AW,
  parameter int WEIGHT_FRAC_BITS             = DFR_FRAC
) (
  input  logic                                    S_AXI_ACLK,
  input  logic                                    S_AXI_ARESETN,
  input  logic                                    start,
  input  logic [31:0]                             num_init_samples,
  input  logic [31:0]                             num_test_samples,
  input  logic [31:0]                             num_steps_per_sample,
  output logic [RESERVOIR_HISTORY_ADDR_WIDTH-1:0] res_rd_addr,
  input  logic [RESERVOIR_DATA_WIDTH-1:0]         res_rd_data,
  output logic [$clog2(NUM_VIRTUAL_NODES)-1:0]    weight_rd_addr,
  input  logic [RESERVOIR_DATA_WIDTH-1:0]         weight_rd_data,
  output logic                                    out_wen,
  output logic [RESERVOIR_HISTORY_ADDR_WIDTH-1:0] out_addr,
  output logic [RESERVOIR_DATA_WIDTH-1:0]         out_data,
  output logic                                    busy,
  output logic                                    done
);
  localparam int W  = RESERVOIR_DATA_WIDTH;
  localparam int AW = RESERVOIR_HISTORY_ADDR_WIDTH;
  localparam int KW = $clog2(NUM_VIRTUAL_NODES);
  dfr_state_t            state, state_d;
  logic [31:0]           test_q, s;
  logic [AW-1:0]         steps_q, base;
  logic                  v1, f1, d;
  logic signed [2*W-1:0] acc;
  // state register
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) state <= IDLE;
    else state <= state_d;
  end
  // next state and per-state strobes
  always_comb begin
    state_d = state;
    busy    = 1'b0;
    done    = 1'b0;
    out_wen = 1'b0;
    case (state)
      IDLE:  if (start) state_d = num_test_samples == '0 ? DONE : ISSUE;
      ISSUE: begin
        busy = 1'b1;
        if (weight_rd_addr == KW'(NUM_VIRTUAL_NODES - 1)) state_d = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (d) state_d = WRITE;
      end
      WRITE: begin
        busy    = 1'b1;
        out_wen = 1'b1;
        state_d = s + 32'd1 == test_q ? DONE : ISSUE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // config latch, sample counter and address generation; the base address advances by the stride each sample
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      test_q         <= '0;
      steps_q        <= '0;
      s              <= '0;
      base           <= '0;
      res_rd_addr    <= '0;
      weight_rd_addr <= '0;
      v1             <= 1'b0;
      f1             <= 1'b0;
      d              <= 1'b0;
    end else begin
      v1 <= state == ISSUE;
      f1 <= state == ISSUE && weight_rd_addr == '0;
      d  <= state == DRAIN && !d;
      if (state == IDLE && start) begin
        test_q  <= num_test_samples;
        steps_q <= num_steps_per_sample[AW-1:0];
        s       <= '0;
        base    <= AW'(num_init_samples * num_steps_per_sample);
        if (state_d == ISSUE) begin
          res_rd_addr    <= AW'(num_init_samples * num_steps_per_sample);
          weight_rd_addr <= '0;
        end
      end
      if (state == ISSUE && state_d == ISSUE) begin
        res_rd_addr    <= res_rd_addr + 1'b1;
        weight_rd_addr <= weight_rd_addr + 1'b1;
      end
      if (state == WRITE) begin
        s <= s + 32'd1;
        if (state_d == ISSUE) begin
          base           <= base + steps_q;
          res_rd_addr    <= base + steps_q;
          weight_rd_addr <= '0;
        end
      end
    end
  end
  dfr_mac #(.W(W)) u_mac (
    .S_AXI_ACLK   (S_AXI_ACLK),
    .S_AXI_ARESETN(S_AXI_ARESETN),
    .in_valid     (v1),
    .clr          (f1),
    .a            (res_rd_data),
    .b            (weight_rd_data),
    .acc          (acc)
  );
  assign out_data = W'(acc >>> WEIGHT_FRAC_BITS);
  assign out_addr = s[AW-1:0];
endmodule

// File: tb/tb_dfr_readout.sv
// tb_dfr_readout: directed vectors for a 4-node and a 100-node readout
module tb_dfr_readout;
  logic        clk = 1'b0;
  logic        rst_n, start_c, sel;
  logic [31:0] init_c, test_c, steps_c;
  int          wmode, hmode;
  logic [15:0] ra_a, oa_a, ra_b, oa_b;
  logic [1:0]  wa_a;
  logic [6:0]  wa_b;
  logic [31:0] rd_a, wd_a, od_a, od_b;
  logic        wen_a, busy_a, done_a, wen_b, busy_b, done_b;
  logic        busy_o, done_o, wen_o;
  logic [15:0] res_o, oaddr_o;
  logic [31:0] odata_o;
  int nvec = 0, nerr = 0;
  int n_wr, cyc, dones, done_at, bcnt;
  int wa[0:15];
  int wd[0:15];
  int ra_log[0:2047];
  always #5 clk = ~clk;
  dfr_readout #(.NUM_VIRTUAL_NODES(4)) dut_a (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .start(start_c & ~sel),
    .num_init_samples(init_c), .num_test_samples(test_c), .num_steps_per_sample(steps_c),
    .res_rd_addr(ra_a), .res_rd_data(rd_a), .weight_rd_addr(wa_a), .weight_rd_data(wd_a),
    .out_wen(wen_a), .out_addr(oa_a), .out_data(od_a), .busy(busy_a), .done(done_a));
  dfr_readout dut_b (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .start(start_c & sel),
    .num_init_samples(init_c), .num_test_samples(test_c), .num_steps_per_sample(steps_c),
    .res_rd_addr(ra_b), .res_rd_data(32'd0), .weight_rd_addr(wa_b), .weight_rd_data(32'd0),
    .out_wen(wen_b), .out_addr(oa_b), .out_data(od_b), .busy(busy_b), .done(done_b));
  assign busy_o  = sel ? busy_b : busy_a;
  assign done_o  = sel ? done_b : done_a;
  assign wen_o   = sel ? wen_b : wen_a;
  assign res_o   = sel ? ra_b : ra_a;
  assign oaddr_o = sel ? oa_b : oa_a;
  assign odata_o = sel ? od_b : od_a;
  function automatic logic [31:0] hist(input logic [15:0] a);
    return hmode == 0 ? {16'd0, a} : hmode == 1 ? 32'd5 : hmode == 2 ? 32'd3 : 32'd1;
  endfunction
  function automatic logic [31:0] wgt(input logic [1:0] k);
    return wmode == 0 ? ({30'd0, k} + 32'd1) << 16 : wmode == 1 ? 32'hFFFF0000 :
           wmode == 2 ? 32'h00008000 : 32'hFFFFFFFF;
  endfunction
  always_ff @(posedge clk) begin
    rd_a <= hist(ra_a);
    wd_a <= wgt(wa_a);
  end
  task automatic chk(input string name, input longint got, input longint exp);
    nvec++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask
  task automatic run(input int i_init, input int i_steps, input int i_test, input int rep_at);
    n_wr = 0; cyc = 0; dones = 0; done_at = -1; bcnt = 0;
    @(negedge clk);
    init_c = i_init; steps_c = i_steps; test_c = i_test; start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (c == rep_at) begin
        start_c = 1'b1; init_c = 7; steps_c = 9; test_c = 3;
      end else start_c = 1'b0;
      if (busy_o | done_o) cyc++;
      if (busy_o) begin
        if (bcnt < 2048) ra_log[bcnt] = int'(res_o);
        bcnt++;
      end
      if (wen_o) begin
        if (n_wr < 16) begin
          wa[n_wr] = int'(oaddr_o);
          wd[n_wr] = int'(odata_o);
        end
        n_wr++;
      end
      if (done_o) begin
        dones++;
        done_at = c;
        break;
      end
      @(negedge clk);
    end
    start_c = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done_o) dones++;
      if (wen_o) n_wr++;
    end
    chk("done_pulses", dones, 1);
  endtask
  typedef struct {
    int init, steps, test, wm, hm, e0, e1, rep;
  } vec_t;
  vec_t v[8];
  initial begin
    v[0] = '{0, 4, 2, 0, 0, 20, 60, -1};
    v[1] = '{0, 4, 1, 1, 1, -20, 0, -1};
    v[2] = '{1, 4, 2, 0, 0, 60, 100, -1};
    v[3] = '{0, 1, 1, 0, 0, 20, 0, -1};
    v[4] = '{3, 0, 2, 0, 0, 20, 20, -1};
    v[5] = '{0, 4, 1, 2, 2, 6, 0, -1};
    v[6] = '{0, 4, 1, 3, 3, -1, 0, -1};
    v[7] = '{0, 4, 2, 0, 0, 20, 60, 5};
    rst_n = 1'b0; start_c = 1'b0; sel = 1'b0;
    init_c = '0; test_c = '0; steps_c = '0; wmode = 0; hmode = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_wen", wen_a, 0);
    chk("rst_addrs", {ra_a, oa_a, 14'd0, wa_a}, 0);
    chk("rst_data", od_a, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wmode = v[i].wm; hmode = v[i].hm;
      run(v[i].init, v[i].steps, v[i].test, v[i].rep);
      chk($sformatf("v%0d_cycles", i), cyc, v[i].test * 7 + 1);
      chk($sformatf("v%0d_done_at", i), done_at, v[i].test * 7);
      chk($sformatf("v%0d_writes", i), n_wr, v[i].test);
      chk($sformatf("v%0d_out0", i), wd[0], v[i].e0);
      chk($sformatf("v%0d_addr0", i), wa[0], 0);
      if (v[i].test > 1) begin
        chk($sformatf("v%0d_out1", i), wd[1], v[i].e1);
        chk($sformatf("v%0d_addr1", i), wa[1], 1);
      end
    end
    run(0, 4, 0, -1);
    chk("zero_cycles", cyc, 1);
    chk("zero_done_at", done_at, 0);
    chk("zero_busy", bcnt, 0);
    chk("zero_writes", n_wr, 0);
    wmode = 0; hmode = 0;
    @(negedge clk);
    init_c = 0; steps_c = 4; test_c = 2; start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    repeat (9) @(negedge clk);
    chk("mid_res_addr", ra_a, 6);
    chk("mid_w_addr", wa_a, 2);
    chk("mid_out_data", od_a, 20);
    chk("mid_out_addr", oa_a, 1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_busy", busy_a, 0);
    chk("rstmid_addrs", {ra_a, oa_a, 14'd0, wa_a}, 0);
    chk("rstmid_data", od_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    n_wr = 0; dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (wen_a) n_wr++;
      if (done_a) dones++;
    end
    chk("rstmid_no_wen", n_wr, 0);
    chk("rstmid_no_done", dones, 0);
    sel = 1'b1;
    run(100, 100, 10, -1);
    chk("big_cycles", cyc, 10 * 103 + 1);
    chk("big_first_addr", ra_log[0], 10000);
    chk("big_last_addr", ra_log[9 * 103 + 99], 10999);
    chk("big_writes", n_wr, 10);
    begin
      int bad = 0;
      for (int i = 0; i < 10; i++) if (wa[i] != i) bad++;
      chk("big_addr_order", bad, 0);
    end
    run(655, 100, 1, -1);
    chk("wrap_first", ra_log[0], 65500);
    chk("wrap_top", ra_log[35], 65535);
    chk("wrap_zero", ra_log[36], 0);
    chk("wrap_last", ra_log[99], 63);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
